zle_enc_param: RTL and testbench

- Parametrised zero run-length encoder with FSM and datapath merged into one block; successor to the fixed 3-bit/4-bit split FSM+DP encoder.
- Nonzero input values pass through tagged as literals. Each run of zero values collapses into one run token carrying the run length.
- Adds valid/ready handshakes on both streams, an explicit end-of-stream (EOS) token with run flush, and a configurable maximum run length.
- Sits between a producer stream and a token consumer in the compression datapath.

---
 rtl/zle_pkg.sv | 23 ++
 rtl/zle_out_slot.sv | 60 ++++++
 rtl/zle_enc_param.sv | 132 +++++++++++++
 tb/tb_zle_enc_param.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zle_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | zle_pkg : shared states and token helpers for zle_enc_param      |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package zle_pkg;

  typedef enum logic [1:0] {
    S_DATA  = 2'd0,
    S_ZEROS = 2'd1,
    S_PEND  = 2'd2,
    S_EOSP  = 2'd3
  } zle_state_e;

  // An EOS token is flagged on o_eos and carries an all-zero o_d.
  localparam int EOS_PAYLOAD = 0;

  function automatic int run_flag_pos(input int w);
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/zle_out_slot.sv
`default_nettype none
// +------------------------------------------------------------------+
// | zle_out_slot : single-entry registered output with valid/ready   |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module zle_out_slot
  import zle_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic [DW-1:0] load_d,
  input  logic          load_eos,
  input  logic          o_ready,
  output logic          slot_free,
  output logic [DW-1:0] o_d,
  output logic          o_eos,
  output logic          o_valid
);

  logic          valid_q, valid_d;
  logic [DW-1:0] d_q, d_d;
  logic          eos_q, eos_d;

  assign slot_free = !valid_q || o_ready;

  // Payload only changes on a load, so it holds through a stall.
  always_comb begin
    valid_d = valid_q;
    d_d     = d_q;
    eos_d   = eos_q;
    if (load) begin
      valid_d = 1'b1;
      d_d     = load_d;
      eos_d   = load_eos;
    end else if (o_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      d_q     <= '0;
      eos_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      d_q     <= d_d;
      eos_q   <= eos_d;
    end
  end

  assign o_valid = valid_q;
  assign o_d     = d_q;
  assign o_eos   = eos_q;

endmodule
`default_nettype wire

// File: rtl/zle_enc_param.sv
`default_nettype none
// +------------------------------------------------------------------+
// | zle_enc_param : parametrised zero run-length encoder with EOS    |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module zle_enc_param
  import zle_pkg::*;
#(
  parameter int W      = 3,
  parameter int MAXRUN = 15,
  parameter int CW     = $clog2(MAXRUN + 1)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] i_d,
  input  logic         i_eos,
  input  logic         i_valid,
  output logic         i_ready,
  output logic [W:0]   o_d,
  output logic         o_eos,
  output logic         o_valid,
  input  logic         o_ready
);

  localparam int            FLAG    = run_flag_pos(W);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAXRUN);
  localparam logic [W:0]    EOS_TOK = (W + 1)'(EOS_PAYLOAD);

  zle_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [W-1:0]  pend_q, pend_d;
  logic          slot_free, load, load_eos, accept;
  logic [W:0]    load_d;

  function automatic logic [W:0] run_tok(input logic [CW-1:0] n);
    logic [W:0] t;
    t          = '0;
    t[W-1:0]   = W'(n);
    t[FLAG]    = 1'b1;
    return t;
  endfunction

  assign cnt_inc = cnt_q + CNT_ONE;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    load     = 1'b0;
    load_d   = '0;
    load_eos = 1'b0;
    i_ready  = slot_free && (state_q == S_DATA || state_q == S_ZEROS);
    accept   = i_valid && i_ready;
    case (state_q)
      S_DATA: if (accept) begin
        if (i_eos) begin
          load     = 1'b1;
          load_eos = 1'b1;
          load_d   = EOS_TOK;
        end else if (i_d != '0) begin
          load   = 1'b1;
          load_d = {1'b0, i_d};
        end else begin
          cnt_d   = CNT_ONE;
          state_d = S_ZEROS;
        end
      end
      S_ZEROS: if (accept) begin
        if (i_eos) begin
          load    = 1'b1;
          load_d  = run_tok(cnt_q);
          cnt_d   = '0;
          state_d = S_EOSP;
        end else if (i_d != '0) begin
          // Run token goes out first; the literal waits one slot in pend.
          load    = 1'b1;
          load_d  = run_tok(cnt_q);
          pend_d  = i_d;
          cnt_d   = '0;
          state_d = S_PEND;
        end else if (cnt_inc == CNT_MAX) begin
          load    = 1'b1;
          load_d  = run_tok(CNT_MAX);
          cnt_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_PEND: if (slot_free) begin
        load    = 1'b1;
        load_d  = {1'b0, pend_q};
        state_d = S_DATA;
      end
      S_EOSP: if (slot_free) begin
        load     = 1'b1;
        load_eos = 1'b1;
        load_d   = EOS_TOK;
        state_d  = S_DATA;
      end
      default: state_d = S_DATA;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_DATA;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  zle_out_slot #(.DW(W + 1)) u_slot (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .load_d    (load_d),
    .load_eos  (load_eos),
    .o_ready   (o_ready),
    .slot_free (slot_free),
    .o_d       (o_d),
    .o_eos     (o_eos),
    .o_valid   (o_valid)
  );

endmodule
`default_nettype wire

// File: tb/tb_zle_enc_param.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_zle_enc_param : directed table + randomised model comparison  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_zle_enc_param;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] i_d;
  logic       i_eos, i_valid, o_ready;

  logic       ir7, ir15, ir2;
  logic [3:0] od7, od2;
  logic [4:0] od15;
  logic       oe7, oe15, oe2, ov7, ov15, ov2;

  int checks = 0;
  int errors = 0;
  int cap7[$];
  int q7[$], q15[$], q2[$];
  int run_m[3];
  int maxr[3];
  bit mon_en = 1'b0;

  always #5 clock = ~clock;

  zle_enc_param #(.W(3), .MAXRUN(7)) dut7 (
    .clock(clock), .reset(reset), .i_d(i_d[2:0]), .i_eos(i_eos), .i_valid(i_valid),
    .i_ready(ir7), .o_d(od7), .o_eos(oe7), .o_valid(ov7), .o_ready(o_ready));

  zle_enc_param #(.W(4), .MAXRUN(15)) dut15 (
    .clock(clock), .reset(reset), .i_d(i_d), .i_eos(i_eos), .i_valid(i_valid),
    .i_ready(ir15), .o_d(od15), .o_eos(oe15), .o_valid(ov15), .o_ready(o_ready));

  zle_enc_param #(.W(3), .MAXRUN(2)) dut2 (
    .clock(clock), .reset(reset), .i_d(i_d[2:0]), .i_eos(i_eos), .i_valid(i_valid),
    .i_ready(ir2), .o_d(od2), .o_eos(oe2), .o_valid(ov2), .o_ready(o_ready));

  // Token as int: literal = value, run = 100 + length, EOS = 1000 (+ any stray payload).
  function automatic int tokv(input bit eos, input bit flag, input int payload);
    if (eos) return 1000 + (flag ? 100 : 0) + payload;
    return (flag ? 100 : 0) + payload;
  endfunction

  int tok7, tok15, tok2;
  assign tok7  = tokv(oe7,  od7[3],  int'(od7[2:0]));
  assign tok15 = tokv(oe15, od15[4], int'(od15[3:0]));
  assign tok2  = tokv(oe2,  od2[3],  int'(od2[2:0]));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic string tokstr();
    string s;
    s = "";
    foreach (cap7[i]) begin
      if (cap7[i] == 1000)     s = {s, "E"};
      else if (cap7[i] > 1000) s = {s, $sformatf("E%0d", cap7[i] - 1000)};
      else if (cap7[i] >= 100) s = {s, $sformatf("R%0d", cap7[i] - 100)};
      else                     s = {s, $sformatf("L%0d", cap7[i])};
    end
    return s;
  endfunction

  // Reference encoder: apply the run/literal/EOS rules to each accepted beat.
  task automatic push_tok(input int k, input int t);
    case (k)
      0: q7.push_back(t);
      1: q15.push_back(t);
      default: q2.push_back(t);
    endcase
  endtask

  task automatic model_beat(input int k, input int d, input bit eos);
    if (eos || d != 0) begin
      if (run_m[k] > 0) push_tok(k, 100 + run_m[k]);
      run_m[k] = 0;
      push_tok(k, eos ? 1000 : d);
    end else begin
      run_m[k]++;
      if (run_m[k] == maxr[k]) begin
        push_tok(k, 100 + maxr[k]);
        run_m[k] = 0;
      end
    end
  endtask

  task automatic check_out(input int k, input int act);
    int e;
    bit emp;
    e = -1;
    case (k)
      0: begin emp = (q7.size() == 0);  if (!emp) e = q7.pop_front();  end
      1: begin emp = (q15.size() == 0); if (!emp) e = q15.pop_front(); end
      default: begin emp = (q2.size() == 0); if (!emp) e = q2.pop_front(); end
    endcase
    checks++;
    if (emp || e != act) begin
      errors++;
      $display("FAIL rand_tok[%0d]: got %0d, expected %0d", k, act, e);
    end
  endtask

  always @(negedge clock) begin
    if (ov7 && o_ready) cap7.push_back(tok7);
    if (mon_en) begin
      if (ov7  && o_ready) check_out(0, tok7);
      if (ov15 && o_ready) check_out(1, tok15);
      if (ov2  && o_ready) check_out(2, tok2);
      if (i_valid && ir7)  model_beat(0, int'(i_d[2:0]), i_eos);
      if (i_valid && ir15) model_beat(1, int'(i_d), i_eos);
      if (i_valid && ir2)  model_beat(2, int'(i_d[2:0]), i_eos);
    end
  end

  // Present one beat to the W=3/MAXRUN=7 instance; returns the cycles spent waiting on i_ready.
  task automatic send_beat(input int d, input bit eos, output int waited);
    i_valid = 1'b1;
    i_d     = d[3:0];
    i_eos   = eos;
    waited  = 0;
    @(negedge clock);
    while (!ir7 && waited < 20) begin
      waited++;
      @(negedge clock);
    end
    if (!ir7) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got i_ready=0, expected 1 within 20 cycles");
    end
    @(posedge clock);
    #1;
    i_valid = 1'b0;
    i_eos   = 1'b0;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  typedef struct {
    string name;
    string ins;
    string exp;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, wsum;
    byte ch;

    maxr[0] = 7; maxr[1] = 15; maxr[2] = 2;
    tbl[0] = '{"lit_run_lit",  "5003",       "L5R2L3"};
    tbl[1] = '{"nine_zeros",   "000000000E", "R7R2E"};
    tbl[2] = '{"lit_eos",      "4E",         "L4E"};
    tbl[3] = '{"zero_eos",     "0E",         "R1E"};
    tbl[4] = '{"maxrun_exact", "00000002",   "R7L2"};
    tbl[5] = '{"lits_eos_lit", "76E1",       "L7L6EL1"};

    reset = 1'b0; i_d = '0; i_eos = 1'b0; i_valid = 1'b0; o_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_o_valid", int'(ov7), 0);
    chk("rst_o_d",     int'(od7), 0);
    chk("rst_o_eos",   int'(oe7), 0);
    chk("rst_i_ready", int'(ir7), 1);
    @(posedge clock); #1;
    reset = 1'b1;
    idle(1);

    foreach (tbl[i]) begin
      cap7.delete();
      for (int c = 0; c < tbl[i].ins.len(); c++) begin
        ch = tbl[i].ins[c];
        if (ch == "E") send_beat(0, 1'b1, w);
        else           send_beat(int'(ch) - 48, 1'b0, w);
      end
      idle(4);
      checks++;
      if (tokstr() != tbl[i].exp) begin
        errors++;
        $display("FAIL tbl_%s: got %s, expected %s", tbl[i].name, tokstr(), tbl[i].exp);
      end
    end

    // Back-to-back beats: only the beat after the run-terminating literal sees a bubble.
    cap7.delete();
    wsum = 0;
    send_beat(5, 1'b0, w); wsum += w;
    send_beat(0, 1'b0, w); wsum += w;
    send_beat(0, 1'b0, w); wsum += w;
    send_beat(3, 1'b0, w); wsum += w;
    chk("bubble_none_before", wsum, 0);
    send_beat(1, 1'b0, w);
    chk("bubble_after_run", w, 1);
    idle(4);
    checks++;
    if (tokstr() != "L5R2L3L1") begin
      errors++;
      $display("FAIL bubble_stream: got %s, expected L5R2L3L1", tokstr());
    end

    // Stall with a run token in the slot and a literal parked in pend.
    cap7.delete();
    send_beat(0, 1'b0, w);
    send_beat(0, 1'b0, w);
    o_ready = 1'b0;
    send_beat(6, 1'b0, w);
    i_valid = 1'b1; i_d = 4'd5; i_eos = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clock);
      chk($sformatf("stall_hold_c%0d", s), int'({ov7, od7, ir7}), int'({1'b1, 4'b1010, 1'b0}));
    end
    @(posedge clock); #1;
    o_ready = 1'b1;
    send_beat(5, 1'b0, w);
    chk("stall_release_bubble", w, 1);
    idle(4);
    checks++;
    if (tokstr() != "R2L6L5") begin
      errors++;
      $display("FAIL stall_stream: got %s, expected R2L6L5", tokstr());
    end

    // Asynchronous reset mid-stream drops the loaded run token and the parked literal.
    cap7.delete();
    send_beat(0, 1'b0, w);
    send_beat(0, 1'b0, w);
    send_beat(0, 1'b0, w);
    send_beat(5, 1'b0, w);
    chk("pre_reset_valid", int'(ov7), 1);
    #1 reset = 1'b0;
    #1;
    chk("async_reset_out", int'({ov7, oe7, od7}), 0);
    @(posedge clock); #1;
    reset = 1'b1;
    send_beat(1, 1'b0, w);
    idle(4);
    checks++;
    if (tokstr() != "L1") begin
      errors++;
      $display("FAIL reset_stream: got %s, expected L1", tokstr());
    end

    // Randomised traffic on all three instances against the reference encoder.
    reset = 1'b0;
    #1;
    q7.delete(); q15.delete(); q2.delete();
    run_m[0] = 0; run_m[1] = 0; run_m[2] = 0;
    @(posedge clock); #1;
    reset = 1'b1;
    mon_en = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      bit zero_heavy;
      zero_heavy = ((cyc / 500) % 2) == 1;
      i_valid = ($urandom_range(3) != 0);
      o_ready = ($urandom_range(3) != 0);
      i_eos   = ($urandom_range(31) == 0);
      if (zero_heavy) i_d = ($urandom_range(7) != 0) ? 4'd0 : 4'($urandom_range(15));
      else            i_d = ($urandom_range(1) != 0) ? 4'd0 : 4'($urandom_range(15));
      @(posedge clock); #1;
    end
    i_valid = 1'b1; i_eos = 1'b1; o_ready = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    i_valid = 1'b0; i_eos = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    mon_en = 1'b0;
    chk("rand_left_w3_m7",  q7.size(),  0);
    chk("rand_left_w4_m15", q15.size(), 0);
    chk("rand_left_w3_m2",  q2.size(),  0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
